// File: rtl/linebuffer_window9.sv
// linebuffer_window9
// Streams raster-order 7-bit pixels and presents a 9x9 neighbourhood window
// through a one-deep valid/ready output stage. Eight line stores hold the
// previous eight rows in a single 56-bit-wide RAM, with one 7-bit lane per row.
// The RAM read is registered, so the read address always points at the
// column of the next pixel to be accepted.
module linebuffer_window9 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [6:0]   in_pixel,
    input  logic         in_valid,
    input  logic         in_sof,
    output logic         in_ready,
    output logic [566:0] win,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_row,
    output logic [4:0]   out_col,
    output logic         frame_done
);

    localparam int PW      = 7;
    localparam int K       = 9;
    localparam int LINES   = K - 1;
    localparam int LW      = PW * LINES;
    localparam int WIN_W   = PW * K * K;
    localparam int CW_RAW  = ($clog2(IMG_W) > $clog2(IMG_H)) ? $clog2(IMG_W) : $clog2(IMG_H);
    localparam int CW      = (CW_RAW < 5) ? 5 : CW_RAW;

    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_FIRST_OK = CW'(K - 1);
    localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_LAST_ROW = CW'(IMG_H - 1);

    // Raster position of the next pixel to be accepted
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    r_row;

    // Output stage
    logic             r_out_valid;
    logic             r_frame_done;
    logic [4:0]       r_out_row;
    logic [4:0]       r_out_col;
    logic [WIN_W-1:0] r_win;

    // Line stores: lane j (bits 7j+6:7j) holds row (current-8+j) at that column
    logic [LW-1:0]    r_line_mem [IMG_W];
    logic [LW-1:0]    r_line_rd;

    // Combinational helpers
    logic             w_xfer;
    logic [CW-1:0]    w_row_eff;
    logic [CW-1:0]    w_col_eff;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_qualify;
    logic [CW-1:0]    w_col_next;
    logic [CW-1:0]    w_row_next;
    logic [CW-1:0]    w_rd_addr;
    logic [PW*K-1:0]  w_new_col;
    logic [LW-1:0]    w_line_wr;
    logic [WIN_W-1:0] w_win_next;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_xfer     = in_valid && in_ready && !rst;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say
    assign w_row_eff  = in_sof ? '0 : r_row;
    assign w_col_eff  = in_sof ? '0 : r_col;
    assign w_last_col = (w_col_eff == C_LAST_COL);
    assign w_last_row = (w_row_eff == C_LAST_ROW);

    // Only windows lying completely inside the image are presented
    assign w_qualify  = (w_row_eff >= C_FIRST_OK) && (w_col_eff >= C_FIRST_OK);

    // New rightmost window column: eight stored rows, then the incoming pixel
    assign w_new_col  = {in_pixel, r_line_rd};

    // Vertical shift at this column: drop the oldest row, append the new pixel
    assign w_line_wr  = w_new_col[PW*K-1:PW];

    // Raster advance and RAM read address for the next accepted pixel
    always_comb begin
        w_col_next = w_col_eff + C_ONE;
        w_row_next = w_row_eff;
        if (w_last_col) begin
            w_col_next = '0;
            w_row_next = w_last_row ? '0 : (w_row_eff + C_ONE);
        end
        w_rd_addr = w_xfer ? w_col_next : r_col;
    end

    // Window shifts one column left; column 8 is refilled from w_new_col
    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_win_row
            for (gj = 0; gj < K - 1; gj++) begin : g_win_col
                assign w_win_next[PW*(K*gi+gj) +: PW] = r_win[PW*(K*gi+gj+1) +: PW];
            end
            assign w_win_next[PW*(K*gi+K-1) +: PW] = w_new_col[PW*gi +: PW];
        end
    endgenerate

    // Line store RAM: write the shifted column on transfer, registered read
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_line_mem[w_col_eff] <= w_line_wr;
        end
        r_line_rd <= r_line_mem[w_rd_addr];
    end

    // Raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // Window register advances on every accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_xfer) begin
            r_win <= w_win_next;
        end
    end

    // Output handshake, window coordinates and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && w_last_row && w_last_col;
            if (w_xfer) begin
                r_out_valid <= w_qualify;
                if (w_qualify) begin
                    r_out_row <= w_row_eff[4:0];
                    r_out_col <= w_col_eff[4:0];
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign win        = r_win;
    assign out_valid  = r_out_valid;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;

endmodule

// File: doc/linebuffer_window9.md
LINEBUFFER_WINDOW9 -- requirements
Module: linebuffer_window9

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning pixels per image row (>= 9).
REQ-002 SHALL have parameter IMG_H, default 28, meaning rows per frame (>= 9).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_pixel  input  7  raster-order pixel, unsigned.
REQ-006 SHALL have port in_valid  input  1  in_pixel valid this cycle.
REQ-007 SHALL have port in_sof  input  1  qualified by in_valid; marks pixel (0,0) of a new frame.
REQ-008 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-009 SHALL have port win  output  567  flat 9x9 window; element k = win[7k+6:7k], k = 9*r + c, r=0 oldest row, c=0 leftmost column.
REQ-010 SHALL have port out_valid  output  1  win holds a complete in-image window.
REQ-011 SHALL have port out_ready  input  1  downstream inner-product stage accepts win.
REQ-012 SHALL have port out_row, out_col  output  5 each  image coordinates of the window's bottom-right pixel (element 80).
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of frame accepted.

Function
REQ-014 Transfer occurs when in_valid && in_ready; SHALL accept at most one pixel per cycle.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational, one-deep output stage).
REQ-016 SHALL keep 8 line stores of IMG_W x 7 bits holding the previous 8 rows; RAM or shift register implementation acceptable.
REQ-017 On each transfer, window register SHALL shift left by one column; new column c=8 takes rows 0..7 from line stores at current column and row 8 from in_pixel; line stores SHALL shift vertically at that column.
REQ-018 Column counter SHALL count 0..IMG_W-1 and wrap to 0 with row increment; row counter SHALL count 0..IMG_H-1 and wrap to 0 after the last pixel.
REQ-019 A transfer with in_sof=1 SHALL force that pixel to coordinate (0,0) regardless of counter state; line store contents need not be cleared.
REQ-020 out_valid SHALL assert the cycle after a transfer at (row, col) with row >= 8 and col >= 8; out_row/out_col SHALL equal that (row, col); latency 1 cycle.
REQ-021 Transfers with row < 8 or col < 8 SHALL update state but not assert out_valid; windows straddling a row boundary SHALL never be presented.
REQ-022 out_valid SHALL clear the cycle after out_valid && out_ready unless a new qualifying transfer occurs in the same cycle (back-to-back windows at full rate).
REQ-023 While out_valid && !out_ready, win, out_row, out_col SHALL hold stable and no pixel SHALL be accepted.
REQ-024 frame_done SHALL pulse one cycle after transfer of pixel (IMG_H-1, IMG_W-1), concurrent with that pixel's out_valid.
REQ-025 Windows per frame SHALL equal (IMG_W-8)*(IMG_H-8); 400 for defaults.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, frame_done=0, out_row=0, out_col=0, win=0, counters=0; line stores need not reset.
REQ-027 rst SHALL override any simultaneous transfer; in_ready SHALL be 1 in the cycle following reset.
REQ-028 Reset mid-frame SHALL discard pending output; next accepted pixel is (0,0).

Verification
REQ-029 Ramp frame, pixel = (row + col) mod 128, out_ready=1 -> 400 windows; first at (8,8), element 0 = 0, element 80 = 16; frame_done once.
REQ-030 Hold out_ready=0 at first window for 5 cycles -> in_ready=0, win/out_row/out_col stable; release -> next window (8,9) follows with no pixel loss.
REQ-031 in_valid toggled randomly 50% -> window sequence and contents identical to REQ-029.
REQ-032 in_sof asserted at pixel (12,3) of a frame -> counters restart; first window at new (8,8) with coordinates 8,8.
REQ-033 rst asserted while out_valid=1 -> next cycle out_valid=0, win=0, in_ready=1; following frame matches REQ-029.
REQ-034 Two frames back-to-back with no idle cycle -> 800 windows, two frame_done pulses, no window spanning frames.
